// File: rtl/cac_uart_pkg.sv
// ---------------------------------------------------------------------------
// cac_uart_pkg
// Shared definitions for the CAC response-side UART transmit path.
//   SOF_BYTE  : start-of-frame marker sent ahead of every response frame
//   txState_t : transmit FSM state encoding (IDLE/START/DATA/STOP)
//   calcDiv   : clock cycles per bit period, truncated
//   frameLen  : bytes per frame (SOF + addr + data bytes + checksum)
// ---------------------------------------------------------------------------
package cac_uart_pkg;

    localparam logic [7:0] SOF_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } txState_t;

    // Whole clock cycles per bit; any fractional remainder is dropped.
    function automatic int calcDiv(input int clkFreq, input int baudRate);
        return clkFreq / baudRate;
    endfunction

    // SOF + address byte + data bytes + checksum byte.
    function automatic int frameLen(input int dataWidth);
        return dataWidth / 8 + 3;
    endfunction

endpackage

// File: rtl/cac_uart_tx_baud.sv
// ---------------------------------------------------------------------------
// cac_uart_tx_baud
// Bit-period counter for the CAC UART transmitter. Counts DIV clock cycles
// and flags the last cycle of each bit period.
// Ports:
//   clk_cac   : CAC clock
//   rst       : asynchronous active-high reset
//   i_restart : realigns the count so a new bit period starts next cycle
//   o_tick    : high during the last cycle of every DIV-cycle bit period
// ---------------------------------------------------------------------------
module cac_uart_tx_baud
    import cac_uart_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk_cac,
    input  logic rst,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(DIV - 1);

    logic [CW-1:0] r_count;

    // Count 0..DIV-1 and wrap, so every bit period is exactly DIV cycles.
    // A restart forces count 0 into the cycle after the restart edge, which
    // lines the first bit period up with the cycle the start bit appears.
    always_ff @(posedge clk_cac or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_restart || (r_count == LAST_COUNT)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tick = (r_count == LAST_COUNT);

endmodule

// File: rtl/cac_uart_tx_framer.sv
// ---------------------------------------------------------------------------
// cac_uart_tx_framer
// Frames one settings read-back response (address + data) as
//   SOF(0xA5), addr, data bytes MSB first, XOR checksum of addr and data
// and sends each byte as 8N1 UART on the CAC TX line.
// Ports:
//   clk_cac    : CAC clock
//   rst        : asynchronous active-high reset
//   rsp_valid  : response offered
//   rsp_ready  : framer idle and able to accept a response
//   rsp_addr   : settings address (one byte)
//   rsp_data   : settings value, DATA_WIDTH bits
//   uart_tx    : serial line, idles high
//   busy       : frame in progress
//   frame_done : one-cycle pulse in the first idle cycle after a frame
// ---------------------------------------------------------------------------
module cac_uart_tx_framer
    import cac_uart_pkg::*;
#(
    parameter int CAC_UART_CLK_FREQ               = 10_000_000,
    parameter int CAC_UART_BAUDRATE               = 115_200,
    parameter int CAC_UART_CH_SETTINGS_ADDR_WIDTH = 8,
    parameter int CAC_UART_CH_SETTINGS_DATA_WIDTH = 32
) (
    input  logic                                       clk_cac,
    input  logic                                       rst,
    input  logic                                       rsp_valid,
    output logic                                       rsp_ready,
    input  logic [CAC_UART_CH_SETTINGS_ADDR_WIDTH-1:0] rsp_addr,
    input  logic [CAC_UART_CH_SETTINGS_DATA_WIDTH-1:0] rsp_data,
    output logic                                       uart_tx,
    output logic                                       busy,
    output logic                                       frame_done
);

    localparam int DW      = CAC_UART_CH_SETTINGS_DATA_WIDTH;
    localparam int DIV     = calcDiv(CAC_UART_CLK_FREQ, CAC_UART_BAUDRATE);
    localparam int NBYTES  = frameLen(DW);
    localparam int NDATA   = DW / 8;
    localparam int IW      = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    // Refuse to elaborate configurations the framing cannot represent.
    if (DIV < 2) begin : g_divCheck
        $error("cac_uart_tx_framer: clock/baud ratio must be at least 2");
    end
    if (CAC_UART_CH_SETTINGS_ADDR_WIDTH != 8) begin : g_addrCheck
        $error("cac_uart_tx_framer: address width must be 8");
    end
    if ((DW % 8) != 0 || DW < 8 || DW > 64) begin : g_dataCheck
        $error("cac_uart_tx_framer: data width must be a multiple of 8 in 8..64");
    end

    txState_t       r_state;
    logic [7:0]     r_addr;
    logic [DW-1:0]  r_data;
    logic [7:0]     r_shift;
    logic [7:0]     r_chk;
    logic [IW-1:0]  r_byteIdx;
    logic [2:0]     r_bitIdx;
    logic           r_tx;
    logic           r_busy;
    logic           r_ready;
    logic           r_done;

    logic           w_accept;
    logic           w_tick;
    logic [IW-1:0]  w_nextIdx;
    logic [7:0]     w_nextByte;

    assign w_accept  = rsp_valid & r_ready;
    assign w_nextIdx = r_byteIdx + 1'b1;

    cac_uart_tx_baud #(
        .DIV (DIV)
    ) u_baud (
        .clk_cac   (clk_cac),
        .rst       (rst),
        .i_restart (w_accept),
        .o_tick    (w_tick)
    );

    // Byte mux for the byte after the current one: address, then the data
    // bytes MSB first, and finally the checksum accumulated so far.
    always_comb begin
        w_nextByte = r_chk;
        if (w_nextIdx == IW'(1)) begin
            w_nextByte = r_addr;
        end
        for (int k = 0; k < NDATA; k++) begin
            if (w_nextIdx == IW'(k + 2)) begin
                w_nextByte = r_data[8*(NDATA-1-k) +: 8];
            end
        end
    end

    // Transmit FSM with registered line and status outputs. The response is
    // shadowed at acceptance so later input changes cannot corrupt the frame.
    // The checksum folds in each byte as it is loaded; folding the checksum
    // byte into itself on the last load is harmless because it is cleared
    // on the next acceptance.
    always_ff @(posedge clk_cac or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_data    <= '0;
            r_shift   <= '0;
            r_chk     <= '0;
            r_byteIdx <= '0;
            r_bitIdx  <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_ready   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr    <= rsp_addr;
                        r_data    <= rsp_data;
                        r_shift   <= SOF_BYTE;
                        r_chk     <= '0;
                        r_byteIdx <= '0;
                        r_tx      <= 1'b0;
                        r_busy    <= 1'b1;
                        r_ready   <= 1'b0;
                        r_state   <= START;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_tx     <= r_shift[0];
                        r_shift  <= {1'b0, r_shift[7:1]};
                        r_bitIdx <= '0;
                        r_state  <= DATA;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_bitIdx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_tx     <= r_shift[0];
                            r_shift  <= {1'b0, r_shift[7:1]};
                            r_bitIdx <= r_bitIdx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (r_byteIdx == LAST_IDX) begin
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_byteIdx <= w_nextIdx;
                            r_shift   <= w_nextByte;
                            r_chk     <= r_chk ^ w_nextByte;
                            r_tx      <= 1'b0;
                            r_state   <= START;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign uart_tx    = r_tx;
    assign busy       = r_busy;
    assign rsp_ready  = r_ready;
    assign frame_done = r_done;

endmodule

// File: tb/tb_cac_uart_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_cac_uart_tx_framer
// Self-checking bench for cac_uart_tx_framer at 1 MHz / 100 kbaud (DIV = 10)
// with 32-bit data. The expected line level for every cycle of a frame is
// derived from the frame byte list and the 8N1 bit layout.
// ---------------------------------------------------------------------------
module tb_cac_uart_tx_framer;

    localparam int CLK_FREQ  = 1_000_000;
    localparam int BAUD      = 100_000;
    localparam int DW        = 32;
    localparam int DIV       = CLK_FREQ / BAUD;
    localparam int NDATA     = DW / 8;
    localparam int NBYTES    = NDATA + 3;
    localparam int FRAME_CYC = NBYTES * 10 * DIV;

    logic          clk_cac   = 1'b0;
    logic          rst       = 1'b1;
    logic          rsp_valid = 1'b0;
    logic [7:0]    rsp_addr  = '0;
    logic [DW-1:0] rsp_data  = '0;
    logic          rsp_ready;
    logic          uart_tx;
    logic          busy;
    logic          frame_done;

    int checkCount = 0;
    int passCount  = 0;

    cac_uart_tx_framer #(
        .CAC_UART_CLK_FREQ               (CLK_FREQ),
        .CAC_UART_BAUDRATE               (BAUD),
        .CAC_UART_CH_SETTINGS_ADDR_WIDTH (8),
        .CAC_UART_CH_SETTINGS_DATA_WIDTH (DW)
    ) dut (
        .clk_cac    (clk_cac),
        .rst        (rst),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_addr   (rsp_addr),
        .rsp_data   (rsp_data),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // 10 time-unit clock period.
    always #5 clk_cac = ~clk_cac;

    // Every comparison goes through here.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Byte idx of the frame for a given response.
    function automatic logic [7:0] modelByte(input logic [7:0] addr,
                                             input logic [DW-1:0] data, input int idx);
        logic [7:0] chk;
        if (idx == 0) return 8'hA5;
        if (idx == 1) return addr;
        if (idx <= NBYTES - 2) return data[DW-8*(idx-1) +: 8];
        chk = addr;
        for (int j = 0; j < NDATA; j++) begin
            chk = chk ^ data[DW-8*(j+1) +: 8];
        end
        return chk;
    endfunction

    // Expected line level in frame cycle c (1 = first start-bit cycle).
    function automatic logic modelLine(input logic [7:0] addr,
                                       input logic [DW-1:0] data, input int c);
        int slot;
        int pos;
        logic [7:0] b;
        slot = (c - 1) / DIV;
        pos  = slot % 10;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        b = modelByte(addr, data, slot / 10);
        return b[pos-1];
    endfunction

    // Offer one response, follow the whole frame cycle by cycle, then check
    // the completion cycle. On cycle 1 the inputs switch to the next values
    // so that later changes are shown to have no effect on this frame.
    task automatic applyStimulus(input logic [7:0] addr, input logic [DW-1:0] data,
                                 input logic holdValid, input logic [7:0] nextAddr,
                                 input logic [DW-1:0] nextData, input string name);
        int waitCycles = 0;
        int lineErr    = 0;
        int sofErr     = 0;
        int busyErr    = 0;
        int readyErr   = 0;
        int doneErr    = 0;
        logic [7:0] decoded [NBYTES];
        for (int i = 0; i < NBYTES; i++) decoded[i] = '0;

        rsp_valid = 1'b1;
        rsp_addr  = addr;
        rsp_data  = data;
        while (rsp_ready !== 1'b1 && waitCycles < 2000) begin
            @(negedge clk_cac);
            waitCycles++;
        end
        if (rsp_ready !== 1'b1) begin
            checkOutput($sformatf("%s_readyTimeout", name), rsp_ready, 1);
            rsp_valid = 1'b0;
            return;
        end
        @(posedge clk_cac);

        for (int c = 1; c <= FRAME_CYC; c++) begin
            int slot;
            int pos;
            @(negedge clk_cac);
            slot = (c - 1) / DIV;
            pos  = slot % 10;
            if (uart_tx !== modelLine(addr, data, c)) begin
                lineErr++;
                if (c <= 10 * DIV) sofErr++;
            end
            if (((c - 1) % DIV) == DIV / 2 && pos >= 1 && pos <= 8) begin
                decoded[slot/10][pos-1] = uart_tx;
            end
            if (busy !== 1'b1) busyErr++;
            if (rsp_ready !== 1'b0) readyErr++;
            if (frame_done !== 1'b0) doneErr++;
            if (c == 1) begin
                rsp_valid = holdValid;
                rsp_addr  = nextAddr;
                rsp_data  = nextData;
            end
        end

        checkOutput($sformatf("%s_sofBitErrors", name), sofErr, 0);
        checkOutput($sformatf("%s_lineBitErrors", name), lineErr, 0);
        for (int i = 0; i < NBYTES; i++) begin
            checkOutput($sformatf("%s_byte%0d", name, i), decoded[i], modelByte(addr, data, i));
        end
        checkOutput($sformatf("%s_busyLowCycles", name), busyErr, 0);
        checkOutput($sformatf("%s_readyHighCycles", name), readyErr, 0);
        checkOutput($sformatf("%s_earlyDoneCycles", name), doneErr, 0);

        // First idle cycle after the last stop bit.
        @(negedge clk_cac);
        checkOutput($sformatf("%s_frameDone", name), frame_done, 1);
        checkOutput($sformatf("%s_readyAfter", name), rsp_ready, 1);
        checkOutput($sformatf("%s_idleLine", name), uart_tx, 1);
        checkOutput($sformatf("%s_busyAfter", name), busy, 0);
    endtask

    // Hard time limit so the bench can never hang.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed time %0t, limit reached before completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]    curAddr;
        logic [DW-1:0] curData;
        logic [7:0]    nAddr;
        logic [DW-1:0] nData;
        logic          hold;
        int            doneSeen;

        // Reset values, with a response offered during reset.
        rsp_valid = 1'b1;
        rsp_addr  = 8'h55;
        rsp_data  = 32'h0BADF00D;
        repeat (3) @(negedge clk_cac);
        checkOutput("rstTx", uart_tx, 1);
        checkOutput("rstReady", rsp_ready, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", frame_done, 0);
        rsp_valid = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("releaseReady", rsp_ready, 0);
        checkOutput("releaseTx", uart_tx, 1);
        @(negedge clk_cac);
        checkOutput("readyFirstClock", rsp_ready, 1);

        // Single reference frame; data changes right after acceptance.
        applyStimulus(8'h12, 32'hDEADBEEF, 1'b0, 8'h34, 32'h12345678, "single");
        @(negedge clk_cac);
        checkOutput("singleDoneOnePulse", frame_done, 0);

        // Back-to-back with rsp_valid held: one idle cycle between frames.
        applyStimulus(8'h01, 32'h00000000, 1'b1, 8'hFF, 32'hFFFFFFFF, "b2bA");
        applyStimulus(8'hFF, 32'hFFFFFFFF, 1'b0, 8'h00, 32'h00000000, "b2bB");
        @(negedge clk_cac);

        // Reset in the middle of the start bit of the third byte.
        rsp_valid = 1'b1;
        rsp_addr  = 8'h12;
        rsp_data  = 32'hDEADBEEF;
        begin
            int w = 0;
            while (rsp_ready !== 1'b1 && w < 2000) begin
                @(negedge clk_cac);
                w++;
            end
        end
        checkOutput("abortReady", rsp_ready, 1);
        @(posedge clk_cac);
        for (int c = 1; c <= 205; c++) begin
            @(negedge clk_cac);
            if (c == 1) rsp_valid = 1'b0;
        end
        checkOutput("abortPreLine", uart_tx, modelLine(8'h12, 32'hDEADBEEF, 205));
        #2;
        rst = 1'b1;
        rsp_valid = 1'b1;
        #1;
        checkOutput("abortTxAsync", uart_tx, 1);
        checkOutput("abortBusyAsync", busy, 0);
        repeat (3) @(negedge clk_cac);
        checkOutput("abortReadyInRst", rsp_ready, 0);
        checkOutput("abortDoneInRst", frame_done, 0);
        rsp_valid = 1'b0;
        rst = 1'b0;
        doneSeen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_cac);
            if (frame_done !== 1'b0) doneSeen++;
        end
        checkOutput("abortNoDone", doneSeen, 0);
        applyStimulus(8'hC3, 32'h0F1E2D3C, 1'b0, 8'h00, 32'h00000000, "postAbort");

        // Randomized responses with random back-to-back or idle gaps.
        curAddr = 8'($urandom);
        curData = $urandom;
        for (int i = 0; i < 6; i++) begin
            nAddr = 8'($urandom);
            nData = $urandom;
            hold  = (i == 5) ? 1'b0 : 1'($urandom_range(0, 1));
            applyStimulus(curAddr, curData, hold, nAddr, nData, $sformatf("rand%0d", i));
            if (hold) begin
                curAddr = nAddr;
                curData = nData;
            end else begin
                @(negedge clk_cac);
                checkOutput($sformatf("rand%0d_donePulseEnd", i), frame_done, 0);
                repeat ($urandom_range(0, 3)) @(negedge clk_cac);
                curAddr = 8'($urandom);
                curData = $urandom;
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
